// File: rtl/remote_transmitter_if.sv
// Key-request / serial-line bundle between a key source (master) and the remote transmitter (slave).
// send/key flow into the transmitter; serial line and status pulses flow back out.
interface remote_transmitter_if;
    logic       send;
    logic [7:0] key;
    logic       serial;
    logic       busy;
    logic       done;
    logic       reject;

    modport master (
        output send,
        output key,
        input  serial,
        input  busy,
        input  done,
        input  reject
    );

    modport slave (
        input  send,
        input  key,
        output serial,
        output busy,
        output done,
        output reject
    );
endinterface

// File: rtl/remote_transmitter.sv
// Remote-control serial emitter: start bit, CUSTOM_CODE, key, ~key, then an idle-high gap. Optional macro REMOTE_TX_KEY_FILTER_EN.
// Latency: start bit one cycle after send is accepted; frame is 1+32+max(GAP_CYCLES,4) cycles.
// Backpressure: send is only sampled in IDLE; requests while busy are dropped, never queued.
module remote_transmitter #(
    parameter logic [15:0] CUSTOM_CODE = 16'h00FF,
    parameter int          GAP_CYCLES  = 4
) (
    input  logic                clk,
    input  logic                rst,
    remote_transmitter_if.slave tx
);

    // The receiver needs at least four idle cycles to re-arm.
    localparam int GAP_EFF = (GAP_CYCLES < 4) ? 4 : GAP_CYCLES;
    localparam int CNT_MAX = (GAP_EFF > 32) ? GAP_EFF : 32;
    localparam int CW      = $clog2(CNT_MAX);
    localparam logic [CW-1:0] LAST_BIT = CW'(31);
    localparam logic [CW-1:0] LAST_GAP = CW'(GAP_EFF - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        SHIFT,
        GAP
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [31:0]   frame, frame_nxt;
    logic          serial_q, serial_nxt;
    logic          busy_q, busy_nxt;
    logic          done_q, done_nxt;
    logic          key_ok;

`ifdef REMOTE_TX_KEY_FILTER_EN
    function automatic logic key_valid(input logic [7:0] k);
        if (k > 8'h1F) return 1'b0;
        return !(k inside {8'h0A, 8'h0B, 8'h0D, 8'h0E, 8'h15, 8'h19, 8'h1C, 8'h1D});
    endfunction

    logic reject_q, reject_nxt;

    assign key_ok     = key_valid(tx.key);
    assign reject_nxt = (state == IDLE) && tx.send && !key_ok;

    // Refusal is reported registered, aligned with where the start bit would have appeared.
    always_ff @(posedge clk) begin
        if (rst) reject_q <= 1'b0;
        else     reject_q <= reject_nxt;
    end

    assign tx.reject = reject_q;
`else
    assign key_ok    = 1'b1;
    assign tx.reject = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        frame_nxt = frame;
        case (state)
            IDLE: begin
                if (tx.send && key_ok) begin
                    state_nxt = START;
                    cnt_nxt   = '0;
                    frame_nxt = {CUSTOM_CODE, tx.key, ~tx.key};
                end
            end
            START: begin
                state_nxt = SHIFT;
                cnt_nxt   = '0;
            end
            SHIFT: begin
                if (cnt == LAST_BIT) begin
                    state_nxt = GAP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + 1'b1;
                    frame_nxt = {frame[30:0], 1'b0};
                end
            end
            GAP: begin
                if (cnt == LAST_GAP) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        serial_nxt = (state_nxt == SHIFT) ? frame_nxt[31] : (state_nxt != START);
        busy_nxt   = (state_nxt != IDLE);
        done_nxt   = (state_nxt == GAP) && (cnt_nxt == LAST_GAP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            frame    <= '0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            frame    <= frame_nxt;
            serial_q <= serial_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
        end
    end

    assign tx.serial = serial_q;
    assign tx.busy   = busy_q;
    assign tx.done   = done_q;

endmodule

// File: tb/tb_remote_transmitter.sv
// Bench for remote_transmitter: default-gap instance plus a GAP_CYCLES=2 instance that must behave identically.
// Expected line activity comes from a per-offset frame model built from {code, key, ~key}.
module tb_remote_transmitter;

    localparam logic [15:0] CC  = 16'h00FF;
    localparam int          GAP = 4;
`ifdef REMOTE_TX_KEY_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    remote_transmitter_if ifa ();
    remote_transmitter_if ifb ();

    remote_transmitter #(.CUSTOM_CODE(CC), .GAP_CYCLES(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .tx  (ifa)
    );

    remote_transmitter #(.CUSTOM_CODE(CC), .GAP_CYCLES(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .tx  (ifb)
    );

    task automatic drive(input logic s, input logic [7:0] k);
        ifa.send = s;
        ifa.key  = k;
        ifb.send = s;
        ifb.key  = k;
    endtask

    function automatic bit key_allowed(input logic [7:0] k);
        bit v;
        v = (k <= 8'h1F) && !(k inside {8'h0A, 8'h0B, 8'h0D, 8'h0E, 8'h15, 8'h19, 8'h1C, 8'h1D});
        return !FILTER || v;
    endfunction

    function automatic logic [7:0] rand_valid_key();
        logic [7:0] k;
        k = 8'($urandom_range(0, 31));
        while (!key_allowed(k)) k = 8'($urandom_range(0, 31));
        return k;
    endfunction

    // Called with inputs drivable (just after a negedge sample); send is accepted on the next posedge (cycle T).
    task automatic do_frame(input logic [7:0] k, input int poke_at, input int rst_at,
                            output logic [31:0] bits);
        logic [31:0] frame;
        logic [3:0]  exp4, obs4;
        logic [2:0]  obs3;
        bit          acc, live;
        frame = {CC, k, ~k};
        acc   = key_allowed(k);
        bits  = '1;
        drive(1'b1, k);
        @(posedge clk);
        for (int off = 1; off <= 38; off++) begin
            @(negedge clk);
            live    = acc && !(rst_at > 0 && off > rst_at);
            exp4[3] = !live ? 1'b1 : (off == 1) ? 1'b0 : (off <= 33) ? frame[33 - off] : 1'b1;
            exp4[2] = live && off <= 33 + GAP;
            exp4[1] = live && off == 33 + GAP;
            exp4[0] = FILTER && !acc && off == 1;
            obs4 = {ifa.serial, ifa.busy, ifa.done, ifa.reject};
            obs3 = {ifb.serial, ifb.busy, ifb.done};
            checks++;
            if (obs4 !== exp4) begin
                errors++;
                $display("FAIL frame_a key=%h off=%0d {serial,busy,done,reject} got=%b exp=%b", k, off, obs4, exp4);
            end
            checks++;
            if (obs3 !== exp4[3:1]) begin
                errors++;
                $display("FAIL frame_gap2 key=%h off=%0d {serial,busy,done} got=%b exp=%b", k, off, obs3, exp4[3:1]);
            end
            if (off >= 2 && off <= 33) bits[33 - off] = ifa.serial;
            rst = (rst_at > 0 && off == rst_at);
            drive(off == poke_at, 8'($urandom));
        end
    endtask

    task automatic test_reset();
        logic [3:0] obs4;
        logic [2:0] obs3;
        rst = 1'b1;
        drive(1'b1, 8'h05);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            obs4 = {ifa.serial, ifa.busy, ifa.done, ifa.reject};
            obs3 = {ifb.serial, ifb.busy, ifb.done};
            checks++;
            if (obs4 !== 4'b1000) begin
                errors++;
                $display("FAIL reset_idle_a cycle=%0d got=%b exp=1000", i, obs4);
            end
            checks++;
            if (obs3 !== 3'b100) begin
                errors++;
                $display("FAIL reset_idle_gap2 cycle=%0d got=%b exp=100", i, obs3);
            end
        end
    endtask

    task automatic test_known_frame();
        logic [31:0] bits;
        do_frame(8'h05, 0, 0, bits);
        checks++;
        if (bits !== 32'h00FF05FA) begin
            errors++;
            $display("FAIL known_frame_bits got=%h exp=00ff05fa", bits);
        end
    endtask

    task automatic test_ignore_and_back_to_back();
        logic [31:0] bits;
        do_frame(rand_valid_key(), 10, 0, bits);
        do_frame(rand_valid_key(), 37, 0, bits);
        do_frame(rand_valid_key(), 0, 0, bits);
    endtask

    task automatic test_random_frames();
        logic [31:0] bits;
        logic [7:0]  k;
        for (int i = 0; i < 6; i++) begin
            k = 8'($urandom);
            do_frame(k, (i % 2 == 0) ? int'($urandom_range(1, 37)) : 0, 0, bits);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] bits;
        do_frame(rand_valid_key(), 0, 15, bits);
        do_frame(8'h12, 0, 0, bits);
        checks++;
        if (bits !== 32'h00FF12ED) begin
            errors++;
            $display("FAIL after_reset_frame_bits got=%h exp=00ff12ed", bits);
        end
    endtask

    task automatic test_key_filter();
        logic [31:0] bits;
        logic [31:0] exp_bits;
        do_frame(8'h0A, 0, 0, bits);
        exp_bits = FILTER ? 32'hFFFFFFFF : 32'h00FF0AF5;
        checks++;
        if (bits !== exp_bits) begin
            errors++;
            $display("FAIL key_0a_bits got=%h exp=%h", bits, exp_bits);
        end
        do_frame(8'h1F, 0, 0, bits);
        checks++;
        if (bits !== 32'h00FF1FE0) begin
            errors++;
            $display("FAIL key_1f_bits got=%h exp=00ff1fe0", bits);
        end
    endtask

    initial begin
        drive(1'b0, 8'h00);
        test_reset();
        test_known_frame();
        test_ignore_and_back_to_back();
        test_random_frames();
        test_reset_mid();
        test_key_filter();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
